// File: rtl/button_pkg.sv
// Shared definitions for the button front end: FSM state encoding and ms-to-cycle math.
package button_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_PRESSED = ST_PRESSED,
    S_LONG    = ST_LONG
  } state_t;

  // Whole-ms cycle count; also used by the debouncer's divider.
  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    return (freq / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Free-running cycle timer: done pulses on the terminal count CYCLES-1, then the count wraps to 0.
module ms_timer #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned      CW   = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;
  localparam logic [CW-1:0]    LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // Combinational so the owner can act on the terminal count in the same cycle.
  assign done = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/button_event_fsm.sv
// Converts the debounced button level into press / release / long-press strobes and a held level.
// Auto-repeat in LONG is built only with `BUTTON_AUTO_REPEAT_EN; release/repeat are reserved words,
// so those strobes are named release_pulse / repeat_pulse.
module button_event_fsm
  import button_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned LONG_MS    = 500,
  parameter int unsigned REPEAT_MS  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stable,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic held,
  output logic repeat_pulse
);

  localparam int unsigned LONG_CYC = ms_to_cycles(CLOCK_FREQ, LONG_MS);

  if (LONG_MS == 0 || REPEAT_MS == 0) begin : g_param_check
    $error("button_event_fsm: LONG_MS and REPEAT_MS must be >= 1");
  end

  state_t state_q, state_d;
  logic   stable_q;
  logic   rise, fall;
  logic   long_clear, long_en, long_done;
  logic   rep_done;
  logic   press_d, release_d, long_d, repeat_d, held_d;

  assign rise = stable & ~stable_q;
  assign fall = ~stable & stable_q;

  // Long-press timer only runs while PRESSED; it is held at 0 elsewhere, so it never wraps in use.
  assign long_clear = (state_q != S_PRESSED);
  assign long_en    = (state_q == S_PRESSED);

  ms_timer #(
    .CYCLES(LONG_CYC)
  ) u_long_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (long_clear),
    .enable (long_en),
    .done   (long_done)
  );

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned REP_CYC = ms_to_cycles(CLOCK_FREQ, REPEAT_MS);

  logic rep_clear, rep_en;

  assign rep_clear = (state_q != S_LONG);
  assign rep_en    = (state_q == S_LONG);

  ms_timer #(
    .CYCLES(REP_CYC)
  ) u_repeat_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rep_clear),
    .enable (rep_en),
    .done   (rep_done)
  );
`else
  assign rep_done = 1'b0;
`endif

  // Next state and strobe decode; a fall always takes priority over a timer terminal count.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
        end
      end
      S_PRESSED: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end else if (long_done) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end
      end
      S_LONG: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end else if (rep_done) begin
          repeat_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    held_d = (state_d == S_PRESSED) || (state_d == S_LONG);
  end

  // stable_q resets high so a button held through reset release is not taken as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      stable_q      <= 1'b1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state_q       <= state_d;
      stable_q      <= stable;
      press         <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
      held          <= held_d;
      repeat_pulse  <= repeat_d;
    end
  end

endmodule
